// File: rtl/e1pkg.sv
// e1pkg: shared E1 line-code symbol tags and pulse polarity constants
package e1pkg;
  typedef enum logic [1:0] {
    ZERO = 2'b00,
    ONE  = 2'b01,
    BSUB = 2'b10,
    VSUB = 2'b11
  } sym_t;
  localparam logic POS = 1'b1;
  localparam logic NEG = 1'b0;
endpackage

// File: rtl/hdb3cnt.sv
// hdb3cnt: saturating, synchronously clearable event counter
module hdb3cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  assign o_cnt = r_cnt;
  // clear wins over increment; hold at all-ones once saturated
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= '0;
    else if (i_inc && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/hdb3enc.sv
// hdb3enc: NRZ to dual-rail HDB3 line encoder; HDB3_AIS_EN adds the AIS all-ones override
module hdb3enc
  import e1pkg::*;
#(
  parameter int CNTW = 16
) (
  input  logic            clk2,
  input  logic            rst,
  input  logic            serin,
  input  logic            aisins,
  input  logic            clrcnt,
  output logic            txpos,
  output logic            txneg,
  output logic [CNTW-1:0] vcnt
);
  sym_t r_s [4];
  logic r_lastpol, r_par;
  sym_t w_in, w_n0, w_n3;
  logic w_pulse, w_isv, w_pol, w_fire, w_par_n;
`ifdef HDB3_AIS_EN
  assign w_in = (serin || aisins) ? ONE : ZERO;
`else
  logic w_ais_unused;
  assign w_ais_unused = aisins;
  assign w_in = serin ? ONE : ZERO;
`endif
  // output polarity of the departing symbol, and the substitution decision taken with parity that already counts it
  always_comb begin
    w_pulse = r_s[3] != ZERO;
    w_isv   = r_s[3] == VSUB;
    w_pol   = w_isv ? r_lastpol : ~r_lastpol;
    w_par_n = w_isv ? 1'b0 : (w_pulse ? ~r_par : r_par);
    w_fire  = w_in == ZERO && r_s[0] == ZERO && r_s[1] == ZERO && r_s[2] == ZERO;
    w_n0    = w_fire ? VSUB : w_in;
    w_n3    = (w_fire && !w_par_n) ? BSUB : r_s[2];
  end
  // symbol shift, registered dual-rail output and running polarity/parity
  always_ff @(posedge clk2)
    if (rst) begin
      r_s       <= '{default: ZERO};
      txpos     <= 1'b0;
      txneg     <= 1'b0;
      r_lastpol <= NEG;
      r_par     <= 1'b0;
    end else begin
      r_s       <= '{w_n0, r_s[0], r_s[1], w_n3};
      txpos     <= w_pulse && w_pol == POS;
      txneg     <= w_pulse && w_pol == NEG;
      r_lastpol <= w_pulse ? w_pol : r_lastpol;
      r_par     <= w_par_n;
    end
  hdb3cnt #(.W(CNTW)) u_cnt (
    .clk  (clk2),
    .rst  (rst),
    .i_clr(clrcnt),
    .i_inc(w_isv),
    .o_cnt(vcnt)
  );
endmodule

// File: tb/tb_hdb3enc.sv
// tb_hdb3enc: directed HDB3 encoder bench with a run-length scan reference model
module tb_hdb3enc;
  localparam int CW = 3;
  localparam int VMAX = 7;
`ifdef HDB3_AIS_EN
  localparam bit AIS = 1'b1;
`else
  localparam bit AIS = 1'b0;
`endif
  logic clk2 = 1'b0, rst = 1'b1, serin = 1'b0, aisins = 1'b0, clrcnt = 1'b0;
  logic txpos, txneg;
  logic [CW-1:0] vcnt;
  hdb3enc #(.CNTW(CW)) dut (
    .clk2  (clk2),
    .rst   (rst),
    .serin (serin),
    .aisins(aisins),
    .clrcnt(clrcnt),
    .txpos (txpos),
    .txneg (txneg),
    .vcnt  (vcnt)
  );
  always #5 clk2 = ~clk2;
  int tests = 0, fails = 0;
  bit chk_en = 1'b0;
  int e_cnt = 0, n_edges = 0;
  bit din [0:63];
  bit ain [0:63];
  bit clr_e [0:127];
  int st [0:131];
  int tg [0:131];
  int ep [0:127];
  int ev [0:127];
  bit cp [0:127];
  bit cn [0:127];
  int cv [0:127];
  // per-cycle comparison of the DUT against the model, sampled mid-cycle
  always @(negedge clk2)
    if (chk_en && e_cnt >= 1 && e_cnt <= n_edges) begin
      tests++;
      if (txpos !== (ep[e_cnt] == 1) || txneg !== (ep[e_cnt] == -1) || vcnt !== CW'(ev[e_cnt])) begin
        fails++;
        $display("FAIL model e=%0d: got pos/neg=%0b%0b vcnt=%0d, required pos/neg=%0b%0b vcnt=%0d",
                 e_cnt, txpos, txneg, vcnt, ep[e_cnt] == 1, ep[e_cnt] == -1, ev[e_cnt]);
      end
    end
  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask
  task automatic clear_stim();
    for (int i = 0; i < 64; i++) begin
      din[i] = 1'b0;
      ain[i] = 1'b0;
    end
    for (int i = 0; i < 128; i++) clr_e[i] = 1'b0;
  endtask
  task automatic set_bits(input string s, output int len);
    clear_stim();
    len = s.len();
    for (int i = 0; i < len; i++) din[i] = s[i] == "1";
  endtask
  // hand-written mark pattern for data bits starting at edge 'first' (+, -, 0)
  task automatic lit(input string nm, input string pat, input int first);
    for (int i = 0; i < pat.len(); i++) begin
      int want, act;
      want = pat[i] == "+" ? 1 : (pat[i] == "-" ? -1 : 0);
      act = cp[first + i] ? 1 : (cn[first + i] ? -1 : 0);
      chk($sformatf("%s[%0d]", nm, i), act, want);
    end
  endtask
  // reset, build the expected line stream, then drive len data bits plus drain zeros
  task automatic run(input int len, input int drain);
    int n, z, par, lp, v;
    n = len + drain;
    rst = 1'b1; serin = 1'b0; aisins = 1'b0; clrcnt = 1'b0; chk_en = 1'b0;
    @(posedge clk2); #1;
    chk("rst_out", int'({txpos, txneg}), 0);
    chk("rst_vcnt", int'(vcnt), 0);
    rst = 1'b0; e_cnt = 0; n_edges = n;
    // line stream: four zeros left from reset, then the effective input bits
    for (int j = 0; j < n + 4; j++)
      st[j] = (j < 4 || j - 4 >= len) ? 0 : ((din[j-4] || (AIS && ain[j-4])) ? 1 : 0);
    // scan zero runs: every fourth unsubstituted zero closes a B00V/000V group
    z = 0; par = 0;
    for (int j = 0; j < n + 4; j++) begin
      tg[j] = st[j];
      z = (j > 0 && st[j] == 0) ? z + 1 : 0;
      if (st[j] == 1) par ^= 1;
      if (z == 4) begin
        if (par == 0) tg[j-3] = 2;
        tg[j] = 3;
        par = 0;
        z = 0;
      end
    end
    lp = -1; v = 0;
    for (int e = 1; e <= n; e++) begin
      if (tg[e-1] == 1 || tg[e-1] == 2) lp = -lp;
      ep[e] = tg[e-1] == 0 ? 0 : lp;
      if (clr_e[e]) v = 0;
      else if (tg[e-1] == 3 && v < VMAX) v++;
      ev[e] = v;
    end
    chk_en = 1'b1;
    for (int e = 1; e <= n; e++) begin
      serin  = (e - 1 < len) ? din[e-1] : 1'b0;
      aisins = (e - 1 < len) ? ain[e-1] : 1'b0;
      clrcnt = clr_e[e];
      @(posedge clk2); #1;
      e_cnt = e;
      cp[e] = txpos;
      cn[e] = txneg;
      cv[e] = int'(vcnt);
    end
    @(negedge clk2); #1;
    chk_en = 1'b0; serin = 1'b0; aisins = 1'b0; clrcnt = 1'b0;
  endtask
  initial begin
    int len;
    set_bits("1100001", len);
    run(len, 6);
    lit("b00v", "+-+00+-", 5);
    chk("b00v_vcnt", cv[13], 1);
    set_bits("100001", len);
    run(len, 6);
    lit("000v", "+000+-", 5);
    chk("000v_vcnt", cv[12], 1);
    clear_stim();
    run(16, 4);
    lit("zeros16", "+-00-+00+-00-+00", 5);
    chk("zeros16_vcnt", cv[20], 4);
    set_bits("1000000001100000", len);
    run(len, 6);
    clear_stim();
    clr_e[41] = 1'b1;
    run(48, 0);
    chk("sat_e33", cv[33], VMAX);
    chk("sat_e37", cv[37], VMAX);
    chk("clr_e41", cv[41], 0);
    chk("after_clr_e45", cv[45], 1);
    clear_stim();
    for (int i = 0; i < 10; i++) ain[i] = 1'b1;
    run(10, 6);
`ifdef HDB3_AIS_EN
    lit("ais", "+-+-+-+-+-", 5);
    chk("ais_vcnt", cv[14], 0);
`else
    lit("ais_off", "+-00-+00+-", 5);
    chk("ais_off_vcnt", cv[14], 3);
`endif
    set_bits("10000", len);
    run(len, 0);
    chk("pre_rst_mark", int'({cp[5], cn[5]}), 2);
    set_bits("1100001", len);
    run(len, 6);
    lit("post_rst", "+-+00+-", 5);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
